mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory arbiter, one transaction in flight
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [1:0]       core_size,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [1:0]       ld_size,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_wdata,
  output logic             core_gnt,
  output logic             core_rvalid,
  output logic             core_err,
  output logic             ld_gnt,
  output logic             ld_rvalid,
  output logic             ld_err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic       OWN_CORE = 1'b0;
  localparam logic       OWN_LD   = 1'b1;
  localparam logic [3:0] LAT_M1   = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_owner_q, last_owner_d;
  logic       owner_q, owner_d;
  logic       we_q, we_d;
  logic       err_q, err_d;

  logic             sel_ld;
  logic             win_we;
  logic [1:0]       win_size;
  logic [WIDTH-1:0] win_addr;
  logic [WIDTH-1:0] win_wdata;
  logic             win_legal;

  // Loader wins only when alone or when the core owned the previous grant.
  always_comb begin
    sel_ld    = ld_req && (!core_req || (last_owner_q == OWN_CORE));
    win_we    = sel_ld ? ld_we    : core_we;
    win_size  = sel_ld ? ld_size  : core_size;
    win_addr  = sel_ld ? ld_addr  : core_addr;
    win_wdata = sel_ld ? ld_wdata : core_wdata;
    win_legal = (win_size != 2'b11) &&
                !((win_size == 2'b01) && win_addr[0]) &&
                !((win_size == 2'b10) && (win_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    err_d        = err_q;
    core_gnt     = 1'b0;
    ld_gnt       = 1'b0;
    core_rvalid  = 1'b0;
    ld_rvalid    = 1'b0;
    core_err     = 1'b0;
    ld_err       = 1'b0;
    rdata        = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_size     = 2'b00;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      S_IDLE: begin
        // Gating with reset keeps every output low while reset is held.
        if (reset && (core_req || ld_req)) begin
          core_gnt     = !sel_ld;
          ld_gnt       = sel_ld;
          owner_d      = sel_ld;
          last_owner_d = sel_ld;
          we_d         = win_we;
          err_d        = !win_legal;
          cnt_d        = LAT_M1;
          state_d      = (MEM_LAT == 1) ? S_DONE : S_WAIT;
          if (win_legal) begin
            mem_en    = 1'b1;
            mem_we    = win_we;
            mem_size  = win_size;
            mem_addr  = win_addr;
            mem_wdata = win_wdata;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        core_rvalid = (owner_q == OWN_CORE);
        ld_rvalid   = (owner_q == OWN_LD);
        core_err    = (owner_q == OWN_CORE) && err_q;
        ld_err      = (owner_q == OWN_LD) && err_q;
        rdata       = (we_q || err_q) ? '0 : mem_rdata;
        cnt_d       = 4'd0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_owner_q <= OWN_LD;
      owner_q      <= OWN_CORE;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench running the directed vectors at MEM_LAT 1..4
module tb_mem_arbiter;

  typedef struct packed {
    logic        who;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_en;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic        who;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ndone  = 0;
  vec_t vecs [8];

  task automatic chk32(input string name, input int lat, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s lat=%0d actual=0x%08h required=0x%08h", name, lat, act, req);
    end
  endtask

  task automatic chk1(input string name, input int lat, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s lat=%0d actual=%b required=%b", name, lat, act, req);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {16'h0, a[15:0]});
  endfunction

  initial begin
    //          who   we    size   addr          wdata          en    err   rdata
    vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 2'b00, 32'h0000_0021, 32'h0000_005A, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 2'b01, 32'h0000_0003, 32'h0000_ABCD, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 32'h0000_0002, 32'h0,         1'b1, 1'b0, 32'hC0DE_0002};
    vecs[4] = '{1'b0, 1'b0, 2'b10, 32'h0000_0002, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 2'b11, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 32'h0000_0007, 32'h0,         1'b1, 1'b0, 32'hC0DE_0007};
    vecs[7] = '{1'b1, 1'b1, 2'b10, 32'h0000_0044, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
  end

  for (genvar g = 0; g < 4; g++) begin : g_lat
    localparam int L = g + 1;

    logic        rst_n;
    logic        core_req, core_we, ld_req, ld_we;
    logic [1:0]  core_size, ld_size;
    logic [31:0] core_addr, core_wdata, ld_addr, ld_wdata;
    logic        core_gnt, core_rvalid, core_err, ld_gnt, ld_rvalid, ld_err;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] pipe [L];
    int          cyc = 0;
    exp_t        q[$];

    mem_arbiter #(.WIDTH(32), .MEM_LAT(L)) dut (
      .clk(clk), .reset(rst_n),
      .core_req(core_req), .core_we(core_we), .core_size(core_size),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_size(ld_size),
      .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_err(core_err),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_err(ld_err),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: read data appears L cycles after the strobe.
    always @(posedge clk) begin
      cyc <= cyc + 1;
      pipe[0] <= (mem_en && !mem_we) ? mem_fn(mem_addr) : 32'hBAD0_BAD0;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    always @(negedge clk) begin
      if (core_rvalid || ld_rvalid) begin
        if (q.size() == 0) begin
          chk32("unexpected_rvalid", L, {30'h0, core_rvalid, ld_rvalid}, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk1("core_rvalid", L, core_rvalid, !e.who);
          chk1("ld_rvalid", L, ld_rvalid, e.who);
          chk1("owner_err", L, e.who ? ld_err : core_err, e.err);
          chk1("other_err", L, e.who ? core_err : ld_err, 1'b0);
          chk32("rdata", L, rdata, e.rdata);
          chk32("rvalid_cycle", L, cyc, e.due);
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic clr_reqs();
      core_req = 0; core_we = 0; core_size = 0; core_addr = 0; core_wdata = 0;
      ld_req = 0; ld_we = 0; ld_size = 0; ld_addr = 0; ld_wdata = 0;
    endtask

    task automatic set_req(input logic who, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
      if (who) begin
        ld_req = 1; ld_we = we; ld_size = sz; ld_addr = a; ld_wdata = wd;
      end else begin
        core_req = 1; core_we = we; core_size = sz; core_addr = a; core_wdata = wd;
      end
    endtask

    task automatic push(input logic who, input logic err, input logic [31:0] rd);
      exp_t e;
      e.who = who; e.err = err; e.rdata = rd; e.due = cyc + L;
      q.push_back(e);
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
        tick();
        n++;
      end
      chk32("drain", L, q.size(), 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
      int waited;
      waited = 0;
      set_req(v.who, v.we, v.size, v.addr, v.wdata);
      #1;
      while (!(v.who ? ld_gnt : core_gnt) && waited < 50) begin
        tick();
        #1;
        waited++;
      end
      chk32("grant_wait", L, waited, 32'h0);
      chk1("other_gnt", L, v.who ? core_gnt : ld_gnt, 1'b0);
      chk1("mem_en", L, mem_en, v.exp_en);
      if (v.exp_en) begin
        chk1("mem_we", L, mem_we, v.we);
        chk32("mem_size", L, {30'h0, mem_size}, {30'h0, v.size});
        chk32("mem_addr", L, mem_addr, v.addr);
        chk32("mem_wdata", L, mem_wdata, v.wdata);
      end
      push(v.who, v.exp_err, v.exp_rdata);
      tick();
      clr_reqs();
      drain();
    endtask

    initial begin
      int n, c, first, rc;
      rst_n = 0;
      clr_reqs();
      set_req(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
      tick();
      #1;
      chk1("rst_core_gnt", L, core_gnt, 1'b0);
      chk1("rst_mem_en", L, mem_en, 1'b0);
      chk32("rst_mem_addr", L, mem_addr, 32'h0);
      tick();
      clr_reqs();
      rst_n = 1;
      #1;
      chk1("idle_gnt", L, core_gnt | ld_gnt, 1'b0);
      chk1("idle_rvalid", L, core_rvalid | ld_rvalid, 1'b0);
      chk1("idle_mem_en", L, mem_en, 1'b0);
      chk32("idle_mem_addr", L, mem_addr, 32'h0);
      chk32("idle_mem_wdata", L, mem_wdata, 32'h0);
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Round robin after reset with both requests held for three grants.
      rst_n = 0;
      set_req(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
      set_req(1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
      tick();
      rst_n = 1;
      n = 0; c = 0; first = 0;
      while (n < 3 && c < 60) begin
        #1;
        chk1("rr_one_gnt", L, core_gnt & ld_gnt, 1'b0);
        if (core_gnt || ld_gnt) begin
          if (n == 0) first = cyc;
          chk1("rr_owner", L, ld_gnt, n[0]);
          chk32("rr_spacing", L, cyc - first, n * (L + 1));
          push(ld_gnt, 1'b0, ld_gnt ? 32'hC0DE_0200 : 32'hC0DE_0100);
          n++;
        end
        tick();
        c++;
      end
      clr_reqs();
      chk32("rr_count", L, n, 32'd3);
      drain();

      // Loader request raised one cycle into a core transaction.
      set_req(1'b0, 1'b0, 2'b10, 32'h40, 32'h0);
      #1;
      chk1("hold_core_gnt", L, core_gnt, 1'b1);
      push(1'b0, 1'b0, 32'hC0DE_0040);
      tick();
      clr_reqs();
      set_req(1'b1, 1'b0, 2'b10, 32'h80, 32'h0);
      for (int k = 1; k <= L + 1; k++) begin
        #1;
        chk1("hold_ld_gnt", L, ld_gnt, k == L + 1);
        if (ld_gnt) push(1'b1, 1'b0, 32'hC0DE_0080);
        tick();
      end
      clr_reqs();
      drain();

      // Reset while the core read is in flight abandons it.
      set_req(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
      #1;
      chk1("abort_core_gnt", L, core_gnt, 1'b1);
      tick();
      clr_reqs();
      rc = (L < 2) ? L : 2;
      for (int k = 1; k < rc; k++) tick();
      rst_n = 0;
      #1;
      chk1("abort_core_rvalid", L, core_rvalid, 1'b0);
      chk1("abort_ld_rvalid", L, ld_rvalid, 1'b0);
      chk1("abort_core_err", L, core_err, 1'b0);
      chk1("abort_mem_en", L, mem_en, 1'b0);
      chk32("abort_rdata", L, rdata, 32'h0);
      tick();
      tick();
      rst_n = 1;
      set_req(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
      set_req(1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
      #1;
      chk1("post_rst_core_gnt", L, core_gnt, 1'b1);
      chk1("post_rst_ld_gnt", L, ld_gnt, 1'b0);
      push(1'b0, 1'b0, 32'hDEAD_BEEF);
      tick();
      clr_reqs();
      drain();
      repeat (3) tick();
      ndone++;
    end
  end

  initial begin
    for (int c = 0; c < 20000 && ndone < 4; c++) @(posedge clk);
    chk32("all_instances_done", 0, ndone, 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
